// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - op encodings and FSM states for the memory-stage sequencer
package mem_access_pkg;

  typedef enum logic [1:0] {
    OP_LW   = 2'b00,
    OP_SW   = 2'b01,
    OP_PUSH = 2'b10,
    OP_POP  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_WAIT   = 2'b10,
    ST_DONE   = 2'b11
  } state_e;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - request/response and data-memory signals of mem_access_ctrl
interface mem_access_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int SP_W   = 7
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [DATA_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              mem_write;
  logic              mem_read;
  logic              dataMemEnable;
  logic [DATA_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [SP_W-1:0]   sp;

  // Environment side: control FSM issues requests, data memory returns data_out
  modport master (
    output req_valid, req_op, req_addr, req_wdata, data_out,
    input  req_ready, mem_write, mem_read, dataMemEnable, address, data_in,
    input  rsp_valid, rsp_rdata, rsp_err, sp
  );

  // Sequencer side
  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, data_out,
    output req_ready, mem_write, mem_read, dataMemEnable, address, data_in,
    output rsp_valid, rsp_rdata, rsp_err, sp
  );
endinterface

// File: rtl/mem_access_ctrl_stack_ptr.sv
// rtl/mem_access_ctrl_stack_ptr.sv - stack occupancy register, stack address and guard (STACK_GUARD_EN)
module stack_ptr
  import mem_access_pkg::*;
#(
  parameter int STACK_DEPTH = 64,
  parameter int SP_W        = 7
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_inc,
  input  logic            i_dec,
  input  logic [1:0]      i_op,
  output logic [SP_W-1:0] o_sp,
  output logic [SP_W-1:0] o_addr,
  output logic            o_guard
);
  localparam logic [SP_W-1:0] L_FULL = SP_W'(STACK_DEPTH);
  localparam logic [SP_W-1:0] L_TOP  = SP_W'(STACK_DEPTH - 1);
  localparam logic [SP_W-1:0] L_ONE  = SP_W'(1);

  logic [SP_W-1:0] r_sp;
  logic [SP_W-1:0] w_sp_nxt;
  logic [SP_W-1:0] w_push_addr;
  logic [SP_W-1:0] w_pop_addr;
  logic            w_full;
  logic            w_empty;

  assign w_full  = (r_sp == L_FULL);
  assign w_empty = (r_sp == '0);

  // Push writes slot sp, pop reads slot sp-1; both wrap at the stack ends
  assign w_push_addr = w_full ? '0 : r_sp;
  assign w_pop_addr  = w_empty ? L_TOP : (r_sp - L_ONE);
  assign o_addr      = (i_op == OP_POP) ? w_pop_addr : w_push_addr;

`ifdef STACK_GUARD_EN
  assign o_guard = ((i_op == OP_PUSH) && w_full) || ((i_op == OP_POP) && w_empty);
`else
  assign o_guard = 1'b0;
`endif

  // Next occupancy: push at full wraps to 0, pop at empty wraps to the top slot
  always_comb begin
    w_sp_nxt = r_sp;
    if (i_inc) begin
      w_sp_nxt = w_full ? '0 : (r_sp + L_ONE);
    end else if (i_dec) begin
      w_sp_nxt = w_empty ? L_TOP : (r_sp - L_ONE);
    end
  end

  // Occupancy register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sp <= '0;
    end else begin
      r_sp <= w_sp_nxt;
    end
  end

  assign o_sp = r_sp;
endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - memory-stage sequencer for LW/SW/PUSH/POP (stack guard under STACK_GUARD_EN)
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int STACK_DEPTH = 64,
  parameter int SP_W        = 7
) (
  input logic               clk,
  input logic               reset_n,
  mem_access_ctrl_if.slave  bus
);
  state_e            r_state;
  state_e            w_next_state;
  op_e               r_op;
  logic              r_mem_write;
  logic              r_mem_read;
  logic              r_dme;
  logic [DATA_W-1:0] r_address;
  logic [DATA_W-1:0] r_data_in;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;

  logic              w_accept;
  logic              w_wr_nxt;
  logic              w_rd_nxt;
  logic              w_dme_nxt;
  logic [DATA_W-1:0] w_address_nxt;
  logic [DATA_W-1:0] w_data_in_nxt;
  logic              w_rsp_valid_nxt;
  logic              w_rsp_err_nxt;
  logic              w_inc;
  logic              w_dec;
  logic              w_guard;
  logic [SP_W-1:0]   w_sp;
  logic [SP_W-1:0]   w_stack_addr;

  stack_ptr #(
    .STACK_DEPTH (STACK_DEPTH),
    .SP_W        (SP_W)
  ) u_stack_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .i_inc   (w_inc),
    .i_dec   (w_dec),
    .i_op    (bus.req_op),
    .o_sp    (w_sp),
    .o_addr  (w_stack_addr),
    .o_guard (w_guard)
  );

  // Next state and next values of the registered strobes/response
  always_comb begin
    w_next_state    = r_state;
    w_accept        = 1'b0;
    w_wr_nxt        = 1'b0;
    w_rd_nxt        = 1'b0;
    w_dme_nxt       = r_dme;
    w_address_nxt   = r_address;
    w_data_in_nxt   = r_data_in;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_err_nxt   = 1'b0;
    w_inc           = 1'b0;
    w_dec           = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          w_accept = 1'b1;
          if (w_guard) begin
            // Stack guard: no memory access, report the abort directly
            w_next_state    = ST_DONE;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b1;
          end else begin
            w_next_state = ST_ACCESS;
            case (op_e'(bus.req_op))
              OP_LW: begin
                w_rd_nxt      = 1'b1;
                w_dme_nxt     = 1'b1;
                w_address_nxt = bus.req_addr;
              end
              OP_SW: begin
                w_wr_nxt      = 1'b1;
                w_dme_nxt     = 1'b1;
                w_address_nxt = bus.req_addr;
                w_data_in_nxt = bus.req_wdata;
              end
              OP_PUSH: begin
                w_wr_nxt      = 1'b1;
                w_dme_nxt     = 1'b0;
                w_address_nxt = {{(DATA_W-SP_W){1'b0}}, w_stack_addr};
                w_data_in_nxt = bus.req_wdata;
              end
              default: begin
                w_rd_nxt      = 1'b1;
                w_dme_nxt     = 1'b0;
                w_address_nxt = {{(DATA_W-SP_W){1'b0}}, w_stack_addr};
              end
            endcase
          end
        end
      end
      ST_ACCESS: begin
        if ((r_op == OP_LW) || (r_op == OP_POP)) begin
          w_next_state = ST_WAIT;
        end else begin
          w_next_state    = ST_DONE;
          w_rsp_valid_nxt = 1'b1;
        end
      end
      ST_WAIT: begin
        w_next_state    = ST_DONE;
        w_rsp_valid_nxt = 1'b1;
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
        w_inc        = (r_op == OP_PUSH) && !r_rsp_err;
        w_dec        = (r_op == OP_POP) && !r_rsp_err;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Registered strobes, latched op and response; read data is captured in WAIT
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op        <= OP_LW;
      r_mem_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_dme       <= 1'b0;
      r_address   <= '0;
      r_data_in   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op <= op_e'(bus.req_op);
      end
      r_mem_write <= w_wr_nxt;
      r_mem_read  <= w_rd_nxt;
      r_dme       <= w_dme_nxt;
      r_address   <= w_address_nxt;
      r_data_in   <= w_data_in_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      if (r_state == ST_WAIT) begin
        r_rsp_rdata <= bus.data_out;
      end
    end
  end

  assign bus.req_ready     = (r_state == ST_IDLE);
  assign bus.mem_write     = r_mem_write;
  assign bus.mem_read      = r_mem_read;
  assign bus.dataMemEnable = r_dme;
  assign bus.address       = r_address;
  assign bus.data_in       = r_data_in;
  assign bus.rsp_valid     = r_rsp_valid;
  assign bus.rsp_rdata     = r_rsp_rdata;
  assign bus.rsp_err       = r_rsp_err;
  assign bus.sp            = w_sp;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed vector bench for mem_access_ctrl (guard tests under STACK_GUARD_EN)
module tb_mem_access_ctrl;
  import mem_access_pkg::*;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int SP_W   = 7;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_wr;
    logic        exp_rd;
    logic        exp_dme;
    logic [31:0] exp_address;
    logic [31:0] exp_din;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_sp;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   rsp_cnt = 0;

  always #5 clk = ~clk;

  mem_access_ctrl_if #(.DATA_W(DATA_W), .SP_W(SP_W)) bus();

  mem_access_ctrl #(.DATA_W(DATA_W), .STACK_DEPTH(DEPTH), .SP_W(SP_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  // Data memory model: static and stack regions, read data one cycle after mem_read
  logic [31:0] smem [0:255];
  logic [31:0] kmem [0:127];
  always @(posedge clk) begin
    if (bus.mem_write) begin
      if (bus.dataMemEnable) smem[bus.address[7:0]] <= bus.data_in;
      else                   kmem[bus.address[6:0]] <= bus.data_in;
    end
    if (bus.mem_read) bus.data_out <= bus.dataMemEnable ? smem[bus.address[7:0]] : kmem[bus.address[6:0]];
    else              bus.data_out <= 32'hBAD0_0BAD;
  end

  // Strobe exclusivity on every cycle, response pulse counter
  always @(negedge clk) begin
    if (reset_n) begin
      checks = checks + 1;
      if (bus.mem_write && bus.mem_read) begin
        errors = errors + 1;
        $display("FAIL excl: mem_write=%b mem_read=%b required not both 1", bus.mem_write, bus.mem_read);
      end
      if (bus.rsp_valid) rsp_cnt = rsp_cnt + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic [1:0] op, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic wr, input logic rd, input logic dme,
                              input logic [31:0] exp_address, input logic [31:0] exp_din,
                              input logic [31:0] exp_rdata, input logic err, input int lat, input int sp);
    vec_t v;
    v.name = nm; v.op = op; v.addr = addr; v.wdata = wdata;
    v.exp_wr = wr; v.exp_rd = rd; v.exp_dme = dme; v.exp_address = exp_address;
    v.exp_din = exp_din; v.exp_rdata = exp_rdata; v.exp_err = err; v.exp_lat = lat; v.exp_sp = sp;
    return v;
  endfunction

  // Issue one request, observe strobes and response, then check occupancy in the following IDLE
  task automatic run_op(input vec_t v);
    int          lat;
    int          strobes;
    logic        g_wr, g_rd, g_dme, g_err;
    logic [31:0] g_addr, g_din, g_rdata;
    lat = 0; strobes = 0;
    g_wr = 0; g_rd = 0; g_dme = 0; g_err = 0; g_addr = 0; g_din = 0; g_rdata = 0;
    @(negedge clk);
    chk({"ready_", v.name}, 32'(bus.req_ready), 32'd1);
    bus.req_op = v.op; bus.req_addr = v.addr; bus.req_wdata = v.wdata; bus.req_valid = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 8 && lat == 0; n++) begin
      @(negedge clk);
      if (n == 1) bus.req_valid = 1'b0;
      if (bus.mem_write || bus.mem_read) begin
        strobes++;
        g_wr = bus.mem_write; g_rd = bus.mem_read; g_dme = bus.dataMemEnable;
        g_addr = bus.address; g_din = bus.data_in;
      end
      if (bus.rsp_valid) begin
        lat = n; g_rdata = bus.rsp_rdata; g_err = bus.rsp_err;
      end
    end
    chk({"lat_", v.name}, 32'(lat), 32'(v.exp_lat));
    chk({"nstrobe_", v.name}, 32'(strobes), v.exp_err ? 32'd0 : 32'd1);
    if (!v.exp_err) begin
      chk({"wr_", v.name}, 32'(g_wr), 32'(v.exp_wr));
      chk({"rd_", v.name}, 32'(g_rd), 32'(v.exp_rd));
      chk({"dme_", v.name}, 32'(g_dme), 32'(v.exp_dme));
      chk({"addr_", v.name}, g_addr, v.exp_address);
      if (v.exp_wr) chk({"din_", v.name}, g_din, v.exp_din);
    end
    chk({"rdata_", v.name}, g_rdata, v.exp_rdata);
    chk({"err_", v.name}, 32'(g_err), 32'(v.exp_err));
    @(negedge clk);
    chk({"sp_", v.name}, 32'(bus.sp), 32'(v.exp_sp));
    chk({"rspoff_", v.name}, 32'(bus.rsp_valid), 32'd0);
  endtask

  vec_t vecs [10];

  initial begin
    int acc, prev, snap;
    vecs[0] = mk("sw10",   OP_SW,   32'h10, 32'hDEADBEEF, 1, 0, 1, 32'h10, 32'hDEADBEEF, 32'h0,        0, 2, 0);
    vecs[1] = mk("lw10",   OP_LW,   32'h10, 32'h0,        0, 1, 1, 32'h10, 32'h0,        32'hDEADBEEF, 0, 3, 0);
    vecs[2] = mk("push11", OP_PUSH, 32'h55, 32'h11,       1, 0, 0, 32'h0,  32'h11,       32'hDEADBEEF, 0, 2, 1);
    vecs[3] = mk("push22", OP_PUSH, 32'h55, 32'h22,       1, 0, 0, 32'h1,  32'h22,       32'hDEADBEEF, 0, 2, 2);
    vecs[4] = mk("push33", OP_PUSH, 32'h55, 32'h33,       1, 0, 0, 32'h2,  32'h33,       32'hDEADBEEF, 0, 2, 3);
    vecs[5] = mk("pop33",  OP_POP,  32'h55, 32'h0,        0, 1, 0, 32'h2,  32'h0,        32'h33,       0, 3, 2);
    vecs[6] = mk("pop22",  OP_POP,  32'h55, 32'h0,        0, 1, 0, 32'h1,  32'h0,        32'h22,       0, 3, 1);
    vecs[7] = mk("pop11",  OP_POP,  32'h55, 32'h0,        0, 1, 0, 32'h0,  32'h0,        32'h11,       0, 3, 0);
    vecs[8] = mk("sw20",   OP_SW,   32'h20, 32'h12345678, 1, 0, 1, 32'h20, 32'h12345678, 32'h11,       0, 2, 0);
    vecs[9] = mk("lw20",   OP_LW,   32'h20, 32'h0,        0, 1, 1, 32'h20, 32'h0,        32'h12345678, 0, 3, 0);

    bus.req_valid = 0; bus.req_op = 0; bus.req_addr = 0; bus.req_wdata = 0;

    // Reset state
    #1;
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_wr", 32'(bus.mem_write), 32'd0);
    chk("rst_rd", 32'(bus.mem_read), 32'd0);
    chk("rst_rspv", 32'(bus.rsp_valid), 32'd0);
    chk("rst_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_sp", 32'(bus.sp), 32'd0);
    chk("rst_addr", bus.address, 32'd0);
    chk("rst_din", bus.data_in, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) run_op(vecs[i]);

    // Back-to-back: req_valid held high across three stores
    snap = rsp_cnt; acc = 0; prev = -1;
    @(negedge clk);
    bus.req_op = OP_SW; bus.req_addr = 32'h30; bus.req_wdata = 32'hC0; bus.req_valid = 1'b1;
    for (int cyc = 0; cyc < 40 && acc < 3; cyc++) begin
      if (bus.req_ready) begin
        if (prev >= 0) chk("b2b_gap", 32'(cyc - prev), 32'd3);
        prev = cyc;
        acc++;
      end
      @(negedge clk);
      if (prev == cyc) begin
        if (acc < 3) begin
          bus.req_addr = 32'h30 + 32'(acc); bus.req_wdata = 32'hC0 + 32'(acc);
        end else begin
          bus.req_valid = 1'b0;
        end
      end
    end
    bus.req_valid = 1'b0;
    chk("b2b_accepts", 32'(acc), 32'd3);
    repeat (4) @(negedge clk);
    chk("b2b_rsp", 32'(rsp_cnt - snap), 32'd3);
    chk("b2b_m0", smem[8'h30], 32'hC0);
    chk("b2b_m1", smem[8'h31], 32'hC1);
    chk("b2b_m2", smem[8'h32], 32'hC2);

    // Reset in the middle of a load
    run_op(mk("push77", OP_PUSH, 32'h0, 32'h77, 1, 0, 0, 32'h0, 32'h77, 32'h12345678, 0, 2, 1));
    @(negedge clk);
    bus.req_op = OP_LW; bus.req_addr = 32'h10; bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("mid_rd_before", 32'(bus.mem_read), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rd", 32'(bus.mem_read), 32'd0);
    chk("mid_wr", 32'(bus.mem_write), 32'd0);
    chk("mid_rspv", 32'(bus.rsp_valid), 32'd0);
    chk("mid_sp", 32'(bus.sp), 32'd0);
    chk("mid_ready", 32'(bus.req_ready), 32'd1);
    snap = rsp_cnt;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid_norsp", 32'(rsp_cnt - snap), 32'd0);

`ifdef STACK_GUARD_EN
    run_op(mk("g_pop0", OP_POP, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 1, 0));
`endif
    // Fill the stack to its full 64 entries
    for (int i = 0; i < DEPTH; i++)
      run_op(mk("fill", OP_PUSH, 32'h0, 32'h1000 + 32'(i), 1, 0, 0, 32'(i), 32'h1000 + 32'(i), 32'h0, 0, 2, i + 1));
`ifdef STACK_GUARD_EN
    run_op(mk("g_push65", OP_PUSH, 32'h0, 32'hA5, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 1, 64));
    run_op(mk("g_pop64", OP_POP, 32'h0, 32'h0, 0, 1, 0, 32'd63, 32'h0, 32'h103F, 0, 3, 63));
`else
    run_op(mk("wrap_push", OP_PUSH, 32'h0, 32'hA5, 1, 0, 0, 32'h0, 32'hA5, 32'h0, 0, 2, 0));
    run_op(mk("wrap_pop0", OP_POP, 32'h0, 32'h0, 0, 1, 0, 32'd63, 32'h0, 32'h103F, 0, 3, 63));
    run_op(mk("wrap_pop63", OP_POP, 32'h0, 32'h0, 0, 1, 0, 32'd62, 32'h0, 32'h103E, 0, 3, 62));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
